// File: rtl/div_engine_p2_if.sv
// Bus bundle between the program-2 divider and its surroundings.
//   Start        CPU launch request (run begins on its falling edge)
//   Ack          run complete, held until the next Start rise
//   MemAddr      data-memory address driven by the engine
//   MemReadData  combinational data-memory read data
//   MemWriteData data-memory write data
//   MemWriteEn   data-memory write strobe
// modport master: the divider engine (it masters the memory port).
// modport slave : the CPU / data-memory side.
interface div_engine_p2_if #(
  parameter int AW = 8
);
  logic          Start;
  logic          Ack;
  logic [AW-1:0] MemAddr;
  logic [7:0]    MemReadData;
  logic [7:0]    MemWriteData;
  logic          MemWriteEn;

  modport master (
    input  Start,
    input  MemReadData,
    output Ack,
    output MemAddr,
    output MemWriteData,
    output MemWriteEn
  );

  modport slave (
    output Start,
    output MemReadData,
    input  Ack,
    input  MemAddr,
    input  MemWriteData,
    input  MemWriteEn
  );
endinterface

// File: rtl/div_engine_p2.sv
// Memory-mapped sequential divider for program 2.
// Reads a 16-bit dividend (MSB first) and an 8-bit divisor from data memory,
// computes floor(dividend*256/divisor) as a 24-bit 16.8 fixed-point value by
// MSB-first restoring division, and writes it back as three bytes (MSB first).
// A zero divisor saturates the result to 24'hFFFFFF without dividing.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous active-high reset
//   bus    div_engine_p2_if.master (Start/Ack handshake + memory port)
module div_engine_p2 #(
  parameter int AW            = 8,
  parameter int DIVIDEND_ADDR = 0,
  parameter int DIVISOR_ADDR  = 2,
  parameter int RESULT_ADDR   = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  div_engine_p2_if.master     bus
);

  localparam logic [AW-1:0] ADDR_DVD0 = AW'(DIVIDEND_ADDR);
  localparam logic [AW-1:0] ADDR_DVD1 = AW'(DIVIDEND_ADDR + 1);
  localparam logic [AW-1:0] ADDR_DVS  = AW'(DIVISOR_ADDR);
  localparam logic [AW-1:0] ADDR_RES0 = AW'(RESULT_ADDR);
  localparam logic [AW-1:0] ADDR_RES1 = AW'(RESULT_ADDR + 1);
  localparam logic [AW-1:0] ADDR_RES2 = AW'(RESULT_ADDR + 2);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, DIV, WR0, WR1, WR2, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic          ack_q, ack_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [23:0]   num_q, num_d;     // dividend extended with 8 zero fraction bits
  logic [7:0]    div_q, div_d;
  logic [23:0]   quot_q, quot_d;
  logic [7:0]    rem_q, rem_d;
  logic [4:0]    cnt_q, cnt_d;

  logic          launch;
  logic          start_rise;
  logic [8:0]    rem9;
  logic [8:0]    diff9;

  assign launch     = start_q & ~bus.Start;
  assign start_rise = bus.Start & ~start_q;

  assign bus.Ack          = ack_q;
  assign bus.MemWriteEn   = we_q;
  assign bus.MemAddr      = addr_q;
  assign bus.MemWriteData = wdata_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      num_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      num_q   <= num_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = bus.Start;
    ack_d   = ack_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    num_d   = num_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rem9    = {rem_q, num_q[cnt_q]};
    diff9   = rem9 - {1'b0, div_q};

    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          // Address is registered, so the first operand address must be
          // presented on the launch edge for the combinational read in RD0.
          state_d = RD0;
          addr_d  = ADDR_DVD0;
          ack_d   = 1'b0;
          quot_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (state_q == DONE && start_rise) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      RD0: begin
        num_d[23:16] = bus.MemReadData;
        addr_d       = ADDR_DVD1;
        state_d      = RD1;
      end
      RD1: begin
        num_d[15:8] = bus.MemReadData;
        num_d[7:0]  = 8'h00;
        addr_d      = ADDR_DVS;
        state_d     = RD2;
      end
      RD2: begin
        div_d = bus.MemReadData;
        if (bus.MemReadData == 8'h00) begin
          quot_d  = 24'hFFFFFF;
          state_d = WR0;
          we_d    = 1'b1;
          addr_d  = ADDR_RES0;
          wdata_d = 8'hFF;
        end else begin
          cnt_d   = 5'd23;
          state_d = DIV;
        end
      end
      DIV: begin
        // rem < divisor always holds, so the restored difference fits 8 bits.
        if (rem9 >= {1'b0, div_q}) begin
          rem_d          = diff9[7:0];
          quot_d[cnt_q]  = 1'b1;
        end else begin
          rem_d          = rem9[7:0];
          quot_d[cnt_q]  = 1'b0;
        end
        if (cnt_q == 5'd0) begin
          state_d = WR0;
          we_d    = 1'b1;
          addr_d  = ADDR_RES0;
          wdata_d = quot_d[23:16];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      WR0: begin
        addr_d  = ADDR_RES1;
        wdata_d = quot_q[15:8];
        state_d = WR1;
      end
      WR1: begin
        addr_d  = ADDR_RES2;
        wdata_d = quot_q[7:0];
        state_d = WR2;
      end
      WR2: begin
        we_d    = 1'b0;
        ack_d   = 1'b1;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_engine_p2.sv
// Self-checking bench for div_engine_p2: behavioural memory with a host
// write port, arithmetic reference model, one task per scenario.
module tb_div_engine_p2;

  logic clk;
  logic rst;

  div_engine_p2_if #(.AW(8)) bus ();

  div_engine_p2 #(
    .AW(8), .DIVIDEND_ADDR(0), .DIVISOR_ADDR(2), .RESULT_ADDR(4)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  int         wr_count;
  int         bad_wr;

  assign bus.MemReadData = mem[bus.MemAddr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.MemWriteEn) begin
      mem[bus.MemAddr] <= bus.MemWriteData;
      wr_count         <= wr_count + 1;
      if (bus.MemAddr < 8'd4 || bus.MemAddr > 8'd6) bad_wr <= bad_wr + 1;
    end
    if (host_we) mem[host_addr] <= host_data;
  end

  int checks;
  int errors;

  function automatic logic [23:0] model(input logic [15:0] dvd, input logic [7:0] dvs);
    logic [31:0] full;
    if (dvs == 8'h00) return 24'hFFFFFF;
    full = ({16'h0000, dvd} * 32'd256) / {24'h000000, dvs};
    return full[23:0];
  endfunction

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  task automatic load(input logic [15:0] dvd, input logic [7:0] dvs, input logic [23:0] sentinel);
    host_write(8'd0, dvd[15:8]);
    host_write(8'd1, dvd[7:0]);
    host_write(8'd2, dvs);
    host_write(8'd4, sentinel[23:16]);
    host_write(8'd5, sentinel[15:8]);
    host_write(8'd6, sentinel[7:0]);
  endtask

  // Start high for two cycles then low; returns at the launch edge.
  task automatic launch();
    @(negedge clk);
    bus.Start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
  endtask

  // Edges after the launch edge until Ack is seen high (60 = timeout).
  task automatic wait_ack(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.Ack) break;
    end
  endtask

  task automatic check_result(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got = {mem[4], mem[5], mem[6]};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s result got %06h expected %06h", name, got, exp);
    end
  endtask

  task automatic check_run(input string name, input logic [15:0] dvd, input logic [7:0] dvs);
    logic [23:0] exp;
    int n, w0, exp_lat;
    exp     = model(dvd, dvs);
    exp_lat = (dvs == 8'h00) ? 6 : 30;
    load(dvd, dvs, ~exp);
    w0 = wr_count;
    launch();
    wait_ack(n);
    checks++;
    if (n !== exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, n, exp_lat);
    end
    check_result(name, exp);
    checks++;
    if (wr_count - w0 !== 3) begin
      errors++;
      $display("FAIL %s write_count got %0d expected 3", name, wr_count - w0);
    end
    checks++;
    if (bad_wr !== 0) begin
      errors++;
      $display("FAIL %s stray_writes got %0d expected 0", name, bad_wr);
    end
    $display("run %s dividend=%0d divisor=%0d result=%06h latency=%0d", name, dvd, dvs,
             {mem[4], mem[5], mem[6]}, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", bus.Ack); end
    checks++;
    if (bus.MemWriteEn !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", bus.MemWriteEn); end
    checks++;
    if (bus.MemAddr !== 8'h00) begin errors++; $display("FAIL reset_addr got %02h expected 00", bus.MemAddr); end
    checks++;
    if (bus.MemWriteData !== 8'h00) begin errors++; $display("FAIL reset_wdata got %02h expected 00", bus.MemWriteData); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.Ack !== 1'b0 || bus.MemWriteEn !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got ack=%b we=%b expected 0/0", bus.Ack, bus.MemWriteEn);
    end
    $display("reset checked");
  endtask

  task automatic test_directed();
    check_run("d385_6", 16'd385, 8'd6);
    check_run("d3_255", 16'd3, 8'd255);
    check_run("d65535_255", 16'd65535, 8'd255);
    check_run("d65535_1", 16'd65535, 8'd1);
    check_run("d0_7", 16'd0, 8'd7);
  endtask

  task automatic test_zero_divisor();
    check_run("zero_div", 16'd1234, 8'd0);
  endtask

  task automatic test_reset_mid_div();
    int w0;
    load(16'd385, 8'd6, 24'h112233);
    w0 = wr_count;
    launch();
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Ack !== 1'b0 || bus.MemWriteEn !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got ack=%b we=%b expected 0/0", bus.Ack, bus.MemWriteEn);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_result("abort_mem", 24'h112233);
    checks++;
    if (wr_count !== w0) begin
      errors++;
      $display("FAIL abort_writes got %0d expected %0d", wr_count - w0, 0);
    end
    $display("reset during DIV cycle 10 checked");
    check_run("after_abort", 16'd385, 8'd6);
  endtask

  task automatic test_back_to_back();
    int n;
    check_run("b2b_first", 16'd385, 8'd6);
    load(16'd1000, 8'd3, 24'h000000);
    checks++;
    if (bus.Ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_hold got %b expected 1", bus.Ack); end
    @(negedge clk);
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got %b expected 0", bus.Ack); end
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    @(posedge clk);
    wait_ack(n);
    checks++;
    if (n !== 30) begin errors++; $display("FAIL b2b_latency got %0d expected 30", n); end
    check_result("b2b_second", 24'h014D55);
    $display("run b2b_second dividend=1000 divisor=3 result=%06h latency=%0d",
             {mem[4], mem[5], mem[6]}, n);
  endtask

  task automatic test_random();
    logic [15:0] dvd;
    logic [7:0]  dvs;
    for (int i = 0; i < 12; i++) begin
      dvd = 16'($urandom);
      dvs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      check_run($sformatf("rand%0d", i), dvd, dvs);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wr_count  = 0;
    bad_wr    = 0;
    host_we   = 1'b0;
    host_addr = 8'h00;
    host_data = 8'h00;
    bus.Start = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_directed();
    test_zero_divisor();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
